pipe_stage: RTL and testbench

Parametrised pipeline stage register that replaces the hard-wired per-field stage registers between decode, execute, memory and writeback. It carries one opaque payload of DW bits with a valid/ready handshake, a synchronous flush that inserts a bubble, and an optional 2-entry skid buffer so that in_ready is a pure register output. It sits between any two pipeline stages. A saturating bubble counter provides stall statistics.

---
 rtl/pipe_stage.sv | 92 +++++++++
 tb/tb_pipe_stage.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage.sv
// Pipeline stage register: opaque DW-bit payload, valid/ready handshake, flush-to-bubble,
// optional 2-entry skid buffer (registered in_ready) and a saturating bubble counter.
module pipe_stage #(
  parameter int              DW      = 32,
  parameter logic [DW-1:0]   RST_VAL = {DW{1'b0}},
  parameter bit              SKID    = 1'b1,
  parameter int              CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] bubble_cnt_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t        state;
  logic [DW-1:0] main_q;
  logic [DW-1:0] skid_q;
  logic [CW-1:0] cnt_q;
  logic          in_fire;
  logic          out_fire;

  assign out_valid    = (state != ST_EMPTY);
  // With the skid buffer in_ready depends only on the state register.
  assign in_ready     = SKID ? (state != ST_FULL) : (!out_valid || out_ready);
  assign in_fire      = in_valid && in_ready;
  assign out_fire     = out_valid && out_ready;
  assign out_data     = main_q;
  assign bubble_cnt_o = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_EMPTY;
      main_q <= RST_VAL;
      skid_q <= RST_VAL;
      cnt_q  <= '0;
    end else begin
      if (!out_valid && (cnt_q != {CW{1'b1}}))
        cnt_q <= cnt_q + CW'(1);

      if (flush_i) begin
        state  <= ST_EMPTY;
        main_q <= RST_VAL;
        skid_q <= RST_VAL;
      end else begin
        case (state)
          ST_EMPTY: begin
            if (in_fire) begin
              state  <= ST_HALF;
              main_q <= in_data;
            end
          end
          ST_HALF: begin
            if (in_fire && out_fire) begin
              main_q <= in_data;
            end else if (in_fire && SKID) begin
              state  <= ST_FULL;
              skid_q <= in_data;
            end else if (out_fire) begin
              state  <= ST_EMPTY;
              main_q <= RST_VAL;
            end
          end
          ST_FULL: begin
            if (out_fire) begin
              state  <= ST_HALF;
              main_q <= skid_q;
              skid_q <= RST_VAL;
            end
          end
          default: begin
            state  <= ST_EMPTY;
            main_q <= RST_VAL;
            skid_q <= RST_VAL;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage.sv
// Directed bench for pipe_stage: skid variant (a), no-skid variant (b), narrow counter (c).
module tb_pipe_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [15:0] a_bubble;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_data, b_out_data;
  logic [15:0] b_bubble;

  logic        c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [7:0]  c_in_data, c_out_data;
  logic [1:0]  c_bubble;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_stage #(.DW(32), .RST_VAL(32'h0000_0013), .SKID(1'b1), .CW(16)) u_a (
    .clk(clk), .rst(rst), .flush_i(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .bubble_cnt_o(a_bubble));

  pipe_stage #(.DW(32), .RST_VAL(32'h0000_0077), .SKID(1'b0), .CW(16)) u_b (
    .clk(clk), .rst(rst), .flush_i(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .bubble_cnt_o(b_bubble));

  pipe_stage #(.DW(8), .RST_VAL(8'h00), .SKID(1'b1), .CW(2)) u_c (
    .clk(clk), .rst(rst), .flush_i(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .bubble_cnt_o(c_bubble));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_cnt [6] = '{1, 2, 3, 3, 3, 3};

    rst = 1'b1;
    a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_in_data = '0;
    b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_in_data = '0;
    c_flush = 0; c_in_valid = 0; c_out_ready = 0; c_in_data = '0;

    // reset
    tick(); tick();
    chk("rst_a_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_a_out_data",  a_out_data, 32'h0000_0013);
    chk("rst_a_in_ready",  32'(a_in_ready), 32'd1);
    chk("rst_a_bubble",    32'(a_bubble), 32'd0);
    chk("rst_b_out_data",  b_out_data, 32'h0000_0077);
    chk("rst_c_bubble",    32'(c_bubble), 32'd0);
    rst = 1'b0;

    // counter saturation, flush does not clear
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("sat_c_bubble_%0d", i), 32'(c_bubble), 32'(exp_cnt[i]));
    end
    c_flush = 1'b1;
    tick();
    c_flush = 1'b0;
    chk("sat_c_after_flush", 32'(c_bubble), 32'd3);
    chk("a_bubble_idle7", 32'(a_bubble), 32'd7);

    // streaming on skid variant
    a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = 32'h1;
    #1 chk("strm_in_ready0", 32'(a_in_ready), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("strm_valid_%0d", i), 32'(a_out_valid), 32'd1);
      chk($sformatf("strm_data_%0d", i), a_out_data, 32'(i));
      chk($sformatf("strm_in_ready_%0d", i), 32'(a_in_ready), 32'd1);
      if (i < 3) a_in_data = 32'(i + 1);
      else       a_in_valid = 1'b0;
    end
    tick();
    chk("strm_drain_valid", 32'(a_out_valid), 32'd0);
    chk("strm_drain_data",  a_out_data, 32'h0000_0013);
    chk("strm_bubble",      32'(a_bubble), 32'd8);

    // backpressure on skid variant
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'hA;
    tick();
    chk("bp_half_data",  a_out_data, 32'hA);
    chk("bp_half_ready", 32'(a_in_ready), 32'd1);
    a_in_data = 32'hB;
    tick();
    chk("bp_full_ready", 32'(a_in_ready), 32'd0);
    chk("bp_full_data",  a_out_data, 32'hA);
    a_in_data = 32'hC;
    tick();
    chk("bp_hold_ready", 32'(a_in_ready), 32'd0);
    chk("bp_hold_data",  a_out_data, 32'hA);
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    tick();
    chk("bp_drain1_data",  a_out_data, 32'hB);
    chk("bp_drain1_ready", 32'(a_in_ready), 32'd1);
    tick();
    chk("bp_drain2_valid", 32'(a_out_valid), 32'd0);
    chk("bp_drain2_data",  a_out_data, 32'h0000_0013);

    // flush while FULL with an input offered
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'hA;
    tick();
    a_in_data = 32'hB;
    tick();
    chk("fl_pre_full", 32'(a_in_ready), 32'd0);
    a_in_data = 32'hC; a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    chk("fl_valid", 32'(a_out_valid), 32'd0);
    chk("fl_data",  a_out_data, 32'h0000_0013);
    chk("fl_ready", 32'(a_in_ready), 32'd1);
    a_in_data = 32'hD;
    tick();
    chk("fl_next_valid", 32'(a_out_valid), 32'd1);
    chk("fl_next_data",  a_out_data, 32'hD);
    // flush in HALF with a simultaneous out_fire and in_fire
    a_out_ready = 1'b1; a_in_data = 32'hE; a_flush = 1'b1;
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    chk("fl2_valid", 32'(a_out_valid), 32'd0);
    chk("fl2_data",  a_out_data, 32'h0000_0013);
    tick();
    chk("fl2_stays_empty", 32'(a_out_valid), 32'd0);

    // backpressure on no-skid variant
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 32'hA;
    #1 chk("ns_empty_ready", 32'(b_in_ready), 32'd1);
    tick();
    b_in_data = 32'hB;
    chk("ns_half_data",  b_out_data, 32'hA);
    chk("ns_half_ready", 32'(b_in_ready), 32'd0);
    tick();
    chk("ns_hold_data",  b_out_data, 32'hA);
    chk("ns_hold_ready", 32'(b_in_ready), 32'd0);
    b_out_ready = 1'b1;
    #1 chk("ns_comb_ready", 32'(b_in_ready), 32'd1);
    tick();
    b_in_valid = 1'b0;
    chk("ns_b_data", b_out_data, 32'hB);
    tick();
    chk("ns_empty_valid", 32'(b_out_valid), 32'd0);
    chk("ns_empty_data",  b_out_data, 32'h0000_0077);

    // reset while FULL
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'h5;
    tick();
    a_in_data = 32'h6;
    tick();
    a_in_valid = 1'b0;
    chk("rf_full", 32'(a_in_ready), 32'd0);
    rst = 1'b1; a_flush = 1'b1;
    tick();
    rst = 1'b0; a_flush = 1'b0;
    chk("rf_valid",  32'(a_out_valid), 32'd0);
    chk("rf_data",   a_out_data, 32'h0000_0013);
    chk("rf_ready",  32'(a_in_ready), 32'd1);
    chk("rf_bubble", 32'(a_bubble), 32'd0);
    a_out_ready = 1'b1;
    tick();
    chk("rf_no_ghost", 32'(a_out_valid), 32'd0);
    chk("rf_bubble1",  32'(a_bubble), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
